// File: rtl/golden_nonce_pacer_pkg.sv
// Shared definitions for the golden-nonce pacer.
// FSM encoding and default widths.
package golden_nonce_pacer_pkg;

    localparam int          NONCE_BITS_DEF      = 32;
    localparam int          FIFO_DEPTH_LOG2_DEF = 2;
    localparam logic [31:0] HOLDOFF_CYCLES_DEF  = 32'd16777216;
    localparam int          DROP_BITS_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/golden_nonce_pacer_nonce_fifo.sv
// Synchronous single-clock FIFO for found nonces.
// Occupancy is kept explicitly so full/empty never alias.
module nonce_fifo
    import golden_nonce_pacer_pkg::*;
#(
    parameter int WIDTH      = NONCE_BITS_DEF,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointer and occupancy registers; pointers wrap at the depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/golden_nonce_pacer.sv
// Paces golden nonces to the UART and LED fade stage.
// Optional duplicate filter: GOLDEN_NONCE_DUP_FILTER_EN.
module golden_nonce_pacer
    import golden_nonce_pacer_pkg::*;
#(
    parameter int          NONCE_BITS      = NONCE_BITS_DEF,
    parameter int          FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter logic [31:0] HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
    parameter int          DROP_BITS       = DROP_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nonce_valid,
    input  logic [NONCE_BITS-1:0]    nonce_in,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [NONCE_BITS-1:0]    tx_data,
    output logic                     trigger,
    output logic [DROP_BITS-1:0]     drop_count,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    tx_valid_q;
    logic                    tx_valid_d;
    logic [NONCE_BITS-1:0]   tx_data_q;
    logic [NONCE_BITS-1:0]   tx_data_d;
    logic                    trigger_q;
    logic                    trigger_d;
    logic [31:0]             cnt_q;
    logic [31:0]             cnt_d;
    logic [DROP_BITS-1:0]    drop_q;
    logic [DROP_BITS-1:0]    drop_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [NONCE_BITS-1:0]   fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    dup;

    nonce_fifo #(
        .WIDTH      (NONCE_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (nonce_in),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

`ifdef GOLDEN_NONCE_DUP_FILTER_EN
    logic [NONCE_BITS-1:0] last_q;
    logic                  last_vld_q;

    assign dup = last_vld_q && (nonce_in == last_q);

    // Remember the most recent nonce that entered the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (fifo_push) begin
            last_q     <= nonce_in;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Accept a nonce if there is room (a same-cycle pop frees a slot),
    // otherwise count it as dropped, saturating at all-ones.
    always_comb begin
        fifo_push = 1'b0;
        drop_d    = drop_q;
        if (nonce_valid && !dup) begin
            if (!fifo_full || fifo_pop) begin
                fifo_push = 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + DROP_BITS'(1);
            end
        end
    end

    // Presentation FSM: load head, wait for handshake, then hold off.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        trigger_d  = 1'b0;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    tx_data_d  = fifo_head;
                    tx_valid_d = 1'b1;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (tx_ready) begin
                    fifo_pop   = 1'b1;
                    tx_valid_d = 1'b0;
                    trigger_d  = 1'b1;
                    cnt_d      = HOLDOFF_CYCLES;
                    if (HOLDOFF_CYCLES != 32'd0) begin
                        state_d = ST_HOLDOFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            trigger_q  <= 1'b0;
            cnt_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            trigger_q  <= trigger_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign trigger    = trigger_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_pacer.sv
// Self-checking bench for golden_nonce_pacer.
// Queue-based reference model plus transmit-order scoreboard.
module tb_golden_nonce_pacer;

    localparam int NB    = 32;
    localparam int LOG2  = 2;
    localparam int DEPTH = 4;
    localparam int H     = 4;
    localparam int DB    = 8;

`ifdef GOLDEN_NONCE_DUP_FILTER_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          nonce_valid = 1'b0;
    logic [NB-1:0] nonce_in = '0;
    logic          tx_ready = 1'b0;
    logic          tx_valid;
    logic [NB-1:0] tx_data;
    logic          trigger;
    logic [DB-1:0] drop_count;
    logic [LOG2:0] fifo_level;

    always #5 clk = ~clk;

    golden_nonce_pacer #(
        .NONCE_BITS      (NB),
        .FIFO_DEPTH_LOG2 (LOG2),
        .HOLDOFF_CYCLES  (32'd4),
        .DROP_BITS       (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nonce_valid (nonce_valid),
        .nonce_in    (nonce_in),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .trigger     (trigger),
        .drop_count  (drop_count),
        .fifo_level  (fifo_level)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [NB-1:0] exp_q[$];

    logic [NB-1:0] mq[$];
    bit            m_valid = 1'b0;
    logic [NB-1:0] m_data = '0;
    bit            m_trig = 1'b0;
    int            m_drop = 0;
    int            idle_at = 0;
    bit            m_last_vld = 1'b0;
    logic [NB-1:0] m_last = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: FIFO as a queue of capacity DEPTH; a word is offered
    // once the pacer is idle (earliest h+H+1 after handshake h) and
    // appears one cycle after that decision.
    initial begin : model
        bit            hs;
        bit            pres;
        logic [NB-1:0] head;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                exp_q.delete();
                m_valid    = 1'b0;
                m_data     = '0;
                m_trig     = 1'b0;
                m_drop     = 0;
                idle_at    = 0;
                m_last_vld = 1'b0;
            end else begin
                hs   = m_valid && tx_ready;
                pres = !m_valid && (cyc >= idle_at) && (mq.size() > 0);
                head = '0;
                if (pres) head = mq[0];
                if (hs) void'(mq.pop_front());
                if (nonce_valid &&
                    !(DUP && m_last_vld && nonce_in == m_last)) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(nonce_in);
                        m_last     = nonce_in;
                        m_last_vld = 1'b1;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
                m_trig = hs;
                if (hs) begin
                    m_valid = 1'b0;
                    idle_at = cyc + 1 + H;
                end
                if (pres) begin
                    m_valid = 1'b1;
                    m_data  = head;
                    exp_q.push_back(head);
                end
            end
            cyc++;
        end
    end

    // Monitor: per-cycle output checks and scoreboard pop on handshake.
    initial begin : monitor
        logic [NB-1:0] e;
        forever begin
            @(negedge clk);
            check("tx_valid", 64'(tx_valid), 64'(m_valid));
            check("trigger", 64'(trigger), 64'(m_trig));
            check("fifo_level", 64'(fifo_level), 64'(mq.size()));
            check("drop_count", 64'(drop_count), 64'(m_drop));
            check("tx_data_reg", 64'(tx_data), 64'(m_data));
            if (tx_valid && tx_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got handshake data %0h expected none (cycle %0d)",
                             tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_tx_data", 64'(tx_data), 64'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] v);
        nonce_valid = 1'b1;
        nonce_in    = v;
        tick();
        nonce_valid = 1'b0;
    endtask

    initial begin : stim
        repeat (3) tick();
        reset = 1'b0;
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);

        tx_ready = 1'b1;
        send(32'hDEADBEEF);
        repeat (10) tick();

        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(32'(i));
        check("five_level", 64'(fifo_level), 64'd4);
        check("five_drop", 64'(drop_count), 64'd1);
        repeat (3) tick();
        tx_ready = 1'b1;
        repeat (30) tick();

        tx_ready = 1'b0;
        for (int i = 10; i <= 13; i++) send(32'(i));
        repeat (3) tick();
        tx_ready    = 1'b1;
        nonce_valid = 1'b1;
        nonce_in    = 32'd14;
        tick();
        nonce_valid = 1'b0;
        tx_ready    = 1'b0;
        check("full_pop_level", 64'(fifo_level), 64'd4);
        check("full_pop_drop", 64'(drop_count), 64'd1);
        tx_ready = 1'b1;
        repeat (40) tick();

        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) send(32'(1000 + i));
        check("drop_sat", 64'(drop_count), 64'd255);
        tx_ready = 1'b1;
        repeat (40) tick();

        tx_ready = 1'b0;
        send(32'd20);
        send(32'd21);
        send(32'd22);
        repeat (3) tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_hold_valid", 64'(tx_valid), 64'd0);
        check("rst_hold_level", 64'(fifo_level), 64'd0);
        check("rst_hold_drop", 64'(drop_count), 64'd0);
        check("rst_hold_trig", 64'(trigger), 64'd0);
        repeat (10) tick();
        tx_ready = 1'b1;
        send(32'd30);
        repeat (10) tick();

        send(32'd7);
        send(32'd7);
        send(32'd8);
        repeat (30) tick();

        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            nonce_valid = ($urandom_range(0, 2) == 0);
            nonce_in    = 32'($urandom_range(0, 5));
            tx_ready    = ($urandom_range(0, 1) == 1);
            tick();
        end
        reset       = 1'b0;
        nonce_valid = 1'b0;
        tx_ready    = 1'b1;
        repeat (60) tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
